// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory loader.
// IMEM_BASE and IMEM_WORDS also define the instruction memory's decoded range.
package imem_pkg;

  // Text-segment base: byte address of instruction word 0.
  localparam logic [31:0] IMEM_BASE  = 32'h0040_0000;
  // Instruction memory depth in 32-bit words.
  localparam int unsigned IMEM_WORDS = 256;
  // Marker byte that opens a frame.
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

  // Loader frame-parsing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a stream of bytes into big-endian 32-bit words.
// The first byte of a word lands in [31:24], the fourth in [7:0].
// o_word_full is high in the same cycle as the strobe of the fourth byte.
// During that cycle, o_word presents the completed word.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        clock,
  input  logic        clear_n,
  input  logic        i_strobe,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  output logic        o_word_full,
  output logic [31:0] o_word
);

  logic [23:0] r_shift;
  logic [1:0]  r_index;

  // Shift accepted bytes in and track the position within the current word.
  always_ff @(posedge clock) begin
    // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside
    // the clocked block and is not in the sensitivity list.
    if (!clear_n || i_clear) begin
      r_shift <= '0;
      r_index <= '0;
    end else if (i_strobe) begin
      // NOTE: state registers use non-blocking assignment.
      // Every register then updates from pre-edge values, with no ordering races.
      r_shift <= {r_shift[15:0], i_byte};
      r_index <= r_index + 2'd1;
    end
  end

  assign o_word_full = i_strobe && (r_index == 2'd3);
  assign o_word      = {r_shift, i_byte};

endmodule

// File: rtl/imem_loader.sv
// Program loader. It parses a framed byte stream with this layout:
//   sync, count, big-endian words, XOR checksum.
// It writes each word to the instruction memory at consecutive word addresses
// from BASE_ADDR, and reports done or error. Only one write is outstanding at a
// time. Byte intake stalls while a write is pending.
module imem_loader
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IMEM_BASE,
  parameter logic [7:0]  SYNC_BYTE = imem_pkg::SYNC_BYTE,
  parameter int unsigned MAX_WORDS = IMEM_WORDS
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_written
);

  loader_state_t r_state;
  logic          r_wr_en;
  logic [31:0]   r_wr_addr;
  logic [31:0]   r_wr_data;
  logic [8:0]    r_words;
  logic [8:0]    r_count;
  logic [7:0]    r_csum;

  logic          w_accept;
  logic          w_wr_fire;
  logic          w_is_sync;
  logic          w_count_ok;
  logic          w_pack_strobe;
  logic          w_pack_clear;
  logic          w_word_full;
  logic [31:0]   w_word;
  logic [8:0]    w_words_next;

  // No byte is taken while a write waits for the memory.
  assign rx_ready      = !r_wr_en;
  assign w_accept      = rx_valid && rx_ready;
  assign w_wr_fire     = r_wr_en && wr_ready;
  assign w_is_sync     = (rx_data == SYNC_BYTE);
  assign w_count_ok    = (rx_data != 8'd0) && (32'(rx_data) <= MAX_WORDS);
  assign w_pack_strobe = w_accept && (r_state == ST_DATA);
  assign w_pack_clear  = w_accept && (r_state == ST_COUNT);
  assign w_words_next  = r_words + 9'd1;

  imem_word_packer u_packer (
    .clock       (clock),
    .clear_n     (clear_n),
    .i_strobe    (w_pack_strobe),
    .i_clear     (w_pack_clear),
    .i_byte      (rx_data),
    .o_word_full (w_word_full),
    .o_word      (w_word)
  );

  // Frame FSM, write request and address/checksum bookkeeping.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state   <= ST_IDLE;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_words   <= '0;
      r_count   <= '0;
      r_csum    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_sync) r_state <= ST_COUNT;
        end

        ST_COUNT: begin
          if (w_accept) begin
            if (w_count_ok) begin
              r_count <= {1'b0, rx_data};
              r_words <= '0;
              r_csum  <= '0;
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_ERROR;
            end
          end
        end

        ST_DATA: begin
          // Byte intake and write completion never overlap: rx_ready is low
          // while a write is pending.
          if (w_accept) begin
            r_csum <= r_csum ^ rx_data;
            if (w_word_full) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= BASE_ADDR + {21'd0, r_words, 2'b00};
              r_wr_data <= w_word;
            end
          end
          if (w_wr_fire) begin
            r_wr_en <= 1'b0;
            r_words <= w_words_next;
            if (w_words_next == r_count) r_state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (w_accept) r_state <= (rx_data == r_csum) ? ST_DONE : ST_ERROR;
        end

        ST_DONE, ST_ERROR: begin
          if (w_accept && w_is_sync) r_state <= ST_COUNT;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign words_written = r_words;
  assign busy          = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign done          = (r_state == ST_DONE);
  assign error         = (r_state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: framing, packing, addressing, checksum,
// write back-pressure, bad count, and mid-frame reset.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  words_written;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  imem_loader dut (
    .clock         (clock),
    .clear_n       (clear_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clock = ~clock;

  // Record every completed write (the memory image as the memory would see it).
  always @(posedge clock) begin
    if (clear_n === 1'b1 && wr_en === 1'b1 && wr_ready === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  // Offer one byte from a negedge; it is accepted on the first posedge with rx_ready high.
  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      $display("FAIL send_byte timeout: rx_ready=%b want 1 (byte %h)", rx_ready, b);
    end else begin
      @(posedge clock);
      @(negedge clock);
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    wr_ready = 1'b1;
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rx_ready !== 1'b1) $display("FAIL reset rx_ready: got %b want 1", rx_ready); else n_pass++;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset wr_en: got %b want 0", wr_en); else n_pass++;
    n_checks++; if (wr_addr !== 32'h0) $display("FAIL reset wr_addr: got %h want 0", wr_addr); else n_pass++;
    n_checks++; if (wr_data !== 32'h0) $display("FAIL reset wr_data: got %h want 0", wr_data); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) $display("FAIL reset flags: busy/done/error got %b%b%b want 000", busy, done, error); else n_pass++;
    n_checks++; if (words_written !== 9'd0) $display("FAIL reset words_written: got %0d want 0", words_written); else n_pass++;
  endtask

  task automatic test_one_word();
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h24); send_byte(8'h08); send_byte(8'h00);
    n_checks++; if (busy !== 1'b1 || wr_en !== 1'b0) $display("FAIL one_word mid: busy/wr_en got %b%b want 10", busy, wr_en); else n_pass++;
    send_byte(8'h05);
    n_checks++; if (wr_en !== 1'b1 || rx_ready !== 1'b0) $display("FAIL one_word write_issue: wr_en/rx_ready got %b%b want 10", wr_en, rx_ready); else n_pass++;
    n_checks++; if (wr_addr !== 32'h0040_0000) $display("FAIL one_word wr_addr: got %h want 00400000", wr_addr); else n_pass++;
    n_checks++; if (wr_data !== 32'h2408_0005) $display("FAIL one_word wr_data: got %h want 24080005", wr_data); else n_pass++;
    send_byte(8'h29);
    n_checks++; if (log_addr.size() != 1) $display("FAIL one_word write_count: got %0d want 1", log_addr.size()); else n_pass++;
    n_checks++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) $display("FAIL one_word flags: done/error/busy got %b%b%b want 100", done, error, busy); else n_pass++;
    n_checks++; if (words_written !== 9'd1) $display("FAIL one_word words_written: got %0d want 1", words_written); else n_pass++;
  endtask

  task automatic test_two_words();
    clear_log();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h20);
    n_checks++; if (log_addr.size() != 2) $display("FAIL two_words write_count: got %0d want 2", log_addr.size());
    else begin
      n_pass++;
      n_checks++; if (log_addr[0] !== 32'h0040_0000 || log_data[0] !== 32'h2001_0001) $display("FAIL two_words write0: got %h@%h want 20010001@00400000", log_data[0], log_addr[0]); else n_pass++;
      n_checks++; if (log_addr[1] !== 32'h0040_0004 || log_data[1] !== 32'h0000_0000) $display("FAIL two_words write1: got %h@%h want 00000000@00400004", log_data[1], log_addr[1]); else n_pass++;
    end
    n_checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL two_words flags: done/error got %b%b want 10", done, error); else n_pass++;
    n_checks++; if (words_written !== 9'd2) $display("FAIL two_words words_written: got %0d want 2", words_written); else n_pass++;
  endtask

  task automatic test_bad_count();
    clear_log();
    send_byte(8'hA5);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL bad_count resync: busy/done got %b%b want 10", busy, done); else n_pass++;
    send_byte(8'h00);
    repeat (2) @(negedge clock);
    n_checks++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) $display("FAIL bad_count flags: error/done/busy got %b%b%b want 100", error, done, busy); else n_pass++;
    n_checks++; if (log_addr.size() != 0 || wr_en !== 1'b0) $display("FAIL bad_count no_write: writes %0d wr_en %b want 0 0", log_addr.size(), wr_en); else n_pass++;
    send_byte(8'hA5);
    n_checks++; if (error !== 1'b0) $display("FAIL bad_count error_clear: got %b want 0", error); else n_pass++;
    send_byte(8'h01); send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05); send_byte(8'h29);
    n_checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL bad_count recover: done/error got %b%b want 10", done, error); else n_pass++;
  endtask

  task automatic test_bad_checksum();
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h28);
    n_checks++; if (log_addr.size() != 1 || log_data[0] !== 32'h2408_0005) $display("FAIL bad_checksum write: count %0d want 1 with data 24080005", log_addr.size()); else n_pass++;
    n_checks++; if (error !== 1'b1 || done !== 1'b0) $display("FAIL bad_checksum flags: error/done got %b%b want 10", error, done); else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_log();
    wr_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    rx_data  = 8'h29;
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (wr_en !== 1'b1 || rx_ready !== 1'b0) $display("FAIL backpressure hold%0d: wr_en/rx_ready got %b%b want 10", i, wr_en, rx_ready); else n_pass++;
      n_checks++; if (wr_addr !== 32'h0040_0000 || wr_data !== 32'h2408_0005) $display("FAIL backpressure stable%0d: got %h@%h want 24080005@00400000", i, wr_data, wr_addr); else n_pass++;
      @(negedge clock);
    end
    n_checks++; if (log_addr.size() != 0 || words_written !== 9'd0) $display("FAIL backpressure early: writes %0d words_written %0d want 0 0", log_addr.size(), words_written); else n_pass++;
    wr_ready = 1'b1;
    send_byte(8'h29);
    n_checks++; if (log_addr.size() != 1 || log_addr[0] !== 32'h0040_0000 || log_data[0] !== 32'h2408_0005) $display("FAIL backpressure image: count %0d want 1 with 24080005@00400000", log_addr.size()); else n_pass++;
    n_checks++; if (done !== 1'b1 || words_written !== 9'd1) $display("FAIL backpressure end: done %b words_written %0d want 1 1", done, words_written); else n_pass++;
  endtask

  task automatic test_reset_pending();
    clear_log();
    wr_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    clear_n = 1'b0;
    @(negedge clock);
    n_checks++; if (wr_en !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_pending: wr_en/rx_ready/busy got %b%b%b want 010", wr_en, rx_ready, busy); else n_pass++;
    n_checks++; if (log_addr.size() != 0) $display("FAIL reset_pending writes: got %0d want 0", log_addr.size()); else n_pass++;
    clear_n  = 1'b1;
    wr_ready = 1'b1;
  endtask

  task automatic test_garbage_reset();
    do_reset();
    send_byte(8'h00); send_byte(8'hFF);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) $display("FAIL garbage idle: busy/done/error got %b%b%b want 000", busy, done, error); else n_pass++;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h24); send_byte(8'h08);
    n_checks++; if (busy !== 1'b1) $display("FAIL garbage sync: busy got %b want 1", busy); else n_pass++;
    clear_n = 1'b0;
    @(negedge clock);
    n_checks++; if (rx_ready !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) $display("FAIL garbage reset_ctl: rx_ready/wr_en/busy/done/error got %b%b%b%b%b want 10000", rx_ready, wr_en, busy, done, error); else n_pass++;
    n_checks++; if (wr_addr !== 32'h0 || wr_data !== 32'h0 || words_written !== 9'd0) $display("FAIL garbage reset_data: wr_addr %h wr_data %h words %0d want 0 0 0", wr_addr, wr_data, words_written); else n_pass++;
    clear_n = 1'b1;
    clear_log();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05); send_byte(8'h29);
    n_checks++; if (log_addr.size() != 1 || log_addr[0] !== 32'h0040_0000 || log_data[0] !== 32'h2408_0005) $display("FAIL garbage fresh_write: count %0d want 1 with 24080005@00400000", log_addr.size()); else n_pass++;
    n_checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL garbage fresh_flags: done/error got %b%b want 10", done, error); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_two_words();
    test_bad_count();
    test_bad_checksum();
    test_backpressure();
    test_reset_pending();
    test_garbage_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory through its write side. Accepts a framed byte stream (sync, word count, big-endian instruction words, XOR checksum) over a valid/ready handshake. Assembles each group of four bytes into a 32-bit word and issues one write per word at consecutive word addresses from the text-segment base. Reports completion or checksum failure so the test harness can release the processor from clear.

## Interface

- BASE_ADDR, 32'h0040_0000, byte address of the first word written (text-segment base)
- SYNC_BYTE, 8'hA5, frame start marker
- MAX_WORDS, 256, instruction memory depth in words; count above this is an error

- clock  input  1  single clock; all state updates on posedge
- clear_n  input  1  reset: synchronous, active-low
- rx_data  input  8  stream byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts byte; transfer when rx_valid && rx_ready at posedge
- wr_en  output  1  write request to instruction memory
- wr_addr  output  32  byte address of write, always word-aligned
- wr_data  output  32  instruction word
- wr_ready  input  1  memory accepts write; write completes when wr_en && wr_ready at posedge
- busy  output  1  frame in progress (COUNT, DATA, CHECK)
- done  output  1  frame loaded, checksum matched; sticky
- error  output  1  bad count or checksum mismatch; sticky
- words_written  output  9  writes completed in the current frame

## Operation

- States: IDLE, COUNT, DATA, CHECK, DONE, ERROR.
- IDLE: rx_ready=1. Accepted byte == SYNC_BYTE goes to COUNT; any other byte is discarded.
- COUNT: accepted byte N. N==0 or N>MAX_WORDS goes to ERROR. Otherwise latch N, clear words_written, byte index and checksum, then go to DATA.
- DATA: bytes are packed big-endian: first byte goes to wr_data[31:24], fourth to [7:0]. Every data byte is XORed into the checksum.
  - After the 4th byte, raise wr_en with wr_addr = BASE_ADDR + 4*words_written.
  - On the wr_ready handshake, words_written++.
  - If words_written now equals N, go to CHECK. Otherwise stay in DATA with byte index 0.
- CHECK: accepted byte equal to the running XOR goes to DONE, else ERROR. The checksum covers data bytes only, not sync or count.
- DONE/ERROR: done/error held high, rx_ready=1. An accepted SYNC_BYTE clears done/error and goes to COUNT. Other bytes are discarded.
- wr_addr/wr_data stay stable while wr_en is high. Only one write is outstanding at a time.
- Memory contents written before an error or reset are left as-is. The loader never erases them.

## Timing

- Reset: clear_n low at posedge puts the block in IDLE. Outputs after reset: rx_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, words_written=0.
- A reset mid-frame abandons the frame. A pending wr_en drops on the same edge.
- Byte throughput: one byte per cycle whenever no write is pending.
- Write latency: wr_en rises the cycle after the 4th byte of a word is accepted.
- While wr_en is high, rx_ready=0, so no byte is accepted during a pending write. The minimum cost is one stall cycle per word.
- wr_en falls the cycle after the wr_ready handshake. rx_ready returns to 1 in that same cycle.
- wr_ready held high: the write completes in its first cycle. This gives a 5-cycle-per-word steady state.
- State transitions from the last write go straight to CHECK. The checksum byte can be accepted on the cycle wr_en falls.
- done/error rise on the posedge that accepts the checksum byte. The count byte triggers error when N is invalid.
- rx_valid low never changes state. Partial words are held indefinitely.

## Structure

- Package imem_pkg:
  - loader state enum
  - SYNC_BYTE
  - IMEM_BASE = 32'h0040_0000 and IMEM_WORDS = 256, shared with the instruction memory's decoded range
- Sub-module imem_word_packer:
  - byte shift register plus 2-bit byte index
  - inputs: byte strobe, clear
  - outputs: word_full, packed word
- FSM, address counter and checksum live in imem_loader.

## Test plan

- Bytes A5 01 24 08 00 05 29 -> one write with wr_addr=0x00400000, wr_data=0x24080005; then done=1, words_written=1, error=0.
- Bytes A5 02 followed by words 0x20010001 and 0x00000000, then checksum 0x20 -> writes at 0x00400000 and 0x00400004; done=1.
- Same 1-word frame with checksum 0x28 -> the write still occurs; then error=1, done=0.
- Count byte 0x00 -> error=1 with no write. A following frame A5 01 … 29 -> error clears and done=1.
- wr_ready held low for 3 cycles during the first write -> wr_en and wr_addr/wr_data stay stable, rx_ready=0 throughout, no byte is lost, final memory image is correct.
- Garbage bytes 00 FF before A5, then clear_n low during DATA after 2 bytes -> garbage ignored; after the reset all outputs are at reset values, and a fresh frame loads normally.
